// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq : WIDTH-bit ALU with valid/ready input, registered {z,n,c,v}       |
// |           flags, carry-chained ADD/SUB and a 1-bit/cycle iterative shifter |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [2:0]         i_op,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_cin_en,
  output logic [WIDTH-1:0]   o_out,
  output logic [3:0]         o_flags,
  output logic               o_out_valid
);

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_AND = 3'd2;
  localparam logic [2:0] c_OP_OR  = 3'd3;
  localparam logic [2:0] c_OP_XOR = 3'd4;
  localparam logic [2:0] c_OP_SHL = 3'd5;
  localparam logic [2:0] c_OP_SHR = 3'd6;
  localparam logic [2:0] c_OP_ASR = 3'd7;

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_SHIFT = 1'b1;

  localparam logic [SHAMT_W-1:0] c_WIDTH_S = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] c_ONE     = SHAMT_W'(1);
  localparam int                 c_MSB     = WIDTH - 1;

  logic [0:0]         r_state;
  logic [0:0]         w_next_state;
  logic [WIDTH-1:0]   r_sh;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2:0]         r_op;
  logic               r_c_kill;

  logic               w_accept;
  logic               w_is_shift;
  logic               w_over;
  logic [SHAMT_W-1:0] w_eff;
  logic               w_long_shift;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_step_a;
  logic [WIDTH:0]     w_step_r;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_chain;
  logic               w_z;

  // One shift step: returns {bit shifted out, shifted value}
  function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] v, input logic [2:0] op);
    logic [WIDTH:0] r;
    case (op)
      c_OP_SHL: r = {v[c_MSB], v[c_MSB-1:0], 1'b0};
      c_OP_SHR: r = {v[0], 1'b0, v[c_MSB:1]};
      default:  r = {v[0], v[c_MSB], v[c_MSB:1]};
    endcase
    return r;
  endfunction

  assign w_accept     = i_in_valid && o_in_ready;
  assign w_is_shift   = (i_op == c_OP_SHL) || (i_op == c_OP_SHR) || (i_op == c_OP_ASR);
  assign w_over       = (i_shamt > c_WIDTH_S);
  assign w_eff        = w_over ? c_WIDTH_S : i_shamt;
  assign w_long_shift = w_is_shift && (w_eff > c_ONE);
  assign w_cin        = i_cin_en && o_flags[1];
  assign w_sum        = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff       = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, w_cin};
  assign w_step_a     = f_step(i_a, i_op);
  assign w_step_r     = f_step(r_sh, r_op);

  always_comb begin
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_chain = 1'b0;
    case (i_op)
      c_OP_ADD: begin
        {w_c, w_res} = w_sum;
        w_v          = (i_a[c_MSB] == i_b[c_MSB]) && (w_sum[c_MSB] != i_a[c_MSB]);
        w_chain      = i_cin_en;
      end
      c_OP_SUB: begin
        {w_c, w_res} = w_diff;
        w_v          = (i_a[c_MSB] != i_b[c_MSB]) && (w_diff[c_MSB] != i_a[c_MSB]);
        w_chain      = i_cin_en;
      end
      c_OP_AND: w_res = i_a & i_b;
      c_OP_OR:  w_res = i_a | i_b;
      c_OP_XOR: w_res = i_a ^ i_b;
      default: begin
        // Only shifts of 0 or 1 complete from IDLE
        if (w_eff == '0) begin
          w_res = i_a;
        end else begin
          {w_c, w_res} = w_step_a;
        end
      end
    endcase
  end

  // Chained ADD/SUB keeps z meaningful across a multi-word result
  assign w_z = (w_res == '0) && (!w_chain || o_flags[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_accept && w_long_shift) w_next_state = c_ST_SHIFT;
      c_ST_SHIFT: if (r_cnt == c_ONE) w_next_state = c_ST_IDLE;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (r_state == c_ST_IDLE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_out       <= '0;
      o_flags     <= 4'b0000;
      o_out_valid <= 1'b0;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_op        <= 3'd0;
      r_c_kill    <= 1'b0;
    end else begin
      o_out_valid <= 1'b0;
      if (r_state == c_ST_IDLE) begin
        if (w_accept) begin
          if (w_long_shift) begin
            r_sh     <= w_step_a[c_MSB:0];
            r_cnt    <= w_eff - c_ONE;
            r_op     <= i_op;
            r_c_kill <= w_over && (i_op != c_OP_ASR);
          end else begin
            o_out       <= w_res;
            o_flags     <= {w_z, w_res[c_MSB], w_c, w_v};
            o_out_valid <= 1'b1;
          end
        end
      end else begin
        r_sh  <= w_step_r[c_MSB:0];
        r_cnt <= r_cnt - c_ONE;
        if (r_cnt == c_ONE) begin
          o_out       <= w_step_r[c_MSB:0];
          o_flags     <= {(w_step_r[c_MSB:0] == '0), w_step_r[c_MSB],
                          w_step_r[WIDTH] & ~r_c_kill, 1'b0};
          o_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_seq : directed and random checks of alu_seq (WIDTH=8)               |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_alu_seq;
  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic [2:0]    op;
  logic [SW-1:0] shamt;
  logic          cin_en;
  logic [W-1:0]  out;
  logic [3:0]    flags;
  logic          out_valid;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] m_flags  = 4'b0000;

  alu_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_op(op), .i_shamt(shamt), .i_cin_en(cin_en),
    .o_out(out), .o_flags(flags), .o_out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Arithmetic reference: result, flags and latency straight from the operation rules
  function automatic void model(input int mop, input logic [7:0] ma, input logic [7:0] mb,
                                input int amt, input bit mcin, output logic [7:0] r,
                                output logic [3:0] f, output int lat);
    int s, sr, sa, sb, ci, full, t;
    bit c, v, chain;
    sa = $signed(ma);
    sb = $signed(mb);
    ci = (mcin && m_flags[1]) ? 1 : 0;
    c = 0; v = 0; chain = 0; lat = 1; r = '0;
    case (mop)
      0: begin
        s = int'(ma) + int'(mb) + ci; r = s[7:0]; c = (s > 255);
        sr = sa + sb + ci; v = (sr > 127) || (sr < -128); chain = mcin;
      end
      1: begin
        s = int'(ma) - int'(mb) - ci; r = s[7:0]; c = (s < 0);
        sr = sa - sb - ci; v = (sr > 127) || (sr < -128); chain = mcin;
      end
      2: r = ma & mb;
      3: r = ma | mb;
      4: r = ma ^ mb;
      default: begin
        lat = (amt == 0) ? 1 : ((amt > W) ? W : amt);
        if (amt == 0) begin
          r = ma;
        end else if (amt > W) begin
          if (mop == 7) begin
            r = (sa < 0) ? 8'hFF : 8'h00;
            c = (sa < 0);
          end else begin
            r = 8'h00;
          end
        end else if (mop == 5) begin
          full = int'(ma) << amt; r = full[7:0]; c = full[8];
        end else if (mop == 6) begin
          full = int'(ma) >> amt; r = full[7:0]; c = ma[amt-1];
        end else begin
          full = sa >>> amt; r = full[7:0];
          t = sa >>> (amt - 1); c = t[0];
        end
      end
    endcase
    f = {chain ? (m_flags[3] && (r == 8'h00)) : (r == 8'h00), r[7], c, v};
    m_flags = f;
  endfunction

  // One isolated operation; garbage is offered while the DUT reports busy
  task automatic do_op(input int mop, input logic [7:0] ma, input logic [7:0] mb,
                       input int amt, input bit mcin);
    logic [7:0] er;
    logic [3:0] ef;
    int elat, lat, busy;
    model(mop, ma, mb, amt, mcin, er, ef, elat);
    chk("ready_idle", in_ready, 1);
    op = 3'(mop); a = ma; b = mb; shamt = SW'(amt); cin_en = mcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy = 0;
    while (!out_valid && lat < 20) begin
      if (!in_ready) begin
        busy++;
        in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk($sformatf("out_valid op%0d", mop), out_valid, 1);
    chk($sformatf("latency op%0d amt%0d", mop, amt), lat, elat);
    chk($sformatf("busy op%0d amt%0d", mop, amt), busy, elat - 1);
    chk($sformatf("out op%0d a%0h b%0h amt%0d", mop, ma, mb, amt), out, er);
    chk($sformatf("flags op%0d a%0h b%0h amt%0d", mop, ma, mb, amt), flags, ef);
    @(posedge clk); #1;
    chk("pulse_once", out_valid, 0);
  endtask

  initial begin
    logic [7:0] er;
    logic [3:0] ef;
    int elat, seen, rop;
    bit rc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; shamt = '0; cin_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_flags", flags, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b0; #1;
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    do_op(0, 8'hFF, 8'h01, 0, 0);
    chk("add_ff_01", {out, flags}, {8'h00, 4'b1010});
    do_op(1, 8'h80, 8'h01, 0, 0);
    chk("sub_80_01", {out, flags}, {8'h7F, 4'b0001});
    do_op(1, 8'h00, 8'h01, 0, 0);
    chk("sub_00_01", {out, flags}, {8'hFF, 4'b0110});
    do_op(0, 8'hFF, 8'h01, 0, 0);
    do_op(0, 8'h00, 8'h00, 0, 1);
    chk("add_chain_hi", {out, flags}, {8'h01, 4'b0000});
    do_op(5, 8'h81, 8'h00, 3, 0);
    chk("shl_81_3", {out, flags[1]}, {8'h08, 1'b0});
    do_op(7, 8'h80, 8'h00, 9, 0);
    chk("asr_80_9", {out, flags[1]}, {8'hFF, 1'b1});
    do_op(5, 8'hA5, 8'h00, 0, 0);
    do_op(6, 8'h01, 8'h00, 1, 0);
    do_op(5, 8'h01, 8'h00, 8, 0);
    do_op(6, 8'hFF, 8'h00, 15, 0);

    // Reset in the middle of a long shift
    do_op(1, 8'h00, 8'h01, 0, 0);
    op = 3'd6; a = 8'hF0; b = '0; shamt = SW'(6); cin_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out", out, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_ready", in_ready, 0);
    rst = 1'b0; #1;
    chk("midrst_ready_after", in_ready, 1);
    m_flags = 4'b0000;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);

    repeat (200) do_op($urandom_range(5, 7), 8'($urandom), 8'($urandom), $urandom_range(0, 15), 0);
    repeat (200) do_op($urandom_range(0, 7), 8'($urandom), 8'($urandom), $urandom_range(0, 15),
                       1'($urandom));

    // Back-to-back stream of single-cycle ops
    for (int k = 0; k < 1500; k++) begin
      rop = $urandom_range(0, 4);
      rc  = 1'($urandom);
      op = 3'(rop); a = 8'($urandom); b = 8'($urandom); shamt = SW'($urandom); cin_en = rc;
      model(rop, a, b, 0, rc, er, ef, elat);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("stream_valid", out_valid, 1);
      chk($sformatf("stream_out k%0d", k), out, er);
      chk($sformatf("stream_flags k%0d", k), flags, ef);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_end_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
